// File: rtl/rr_arb16_pkg.sv
// Shared constants for the 16-way round-robin arbiter.
// State encodings and requester sizing.
package rr_arb16_pkg;
    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;
endpackage

// File: rtl/rr_arb16_deco416.sv
// 4-to-16 one-hot decoder.
// Output bit x is set, all others clear.
module deco416 (
    input  logic [3:0]  x,
    output logic [15:0] o
);
    assign o = 16'h0001 << x;
endmodule

// File: rtl/rr_arb16.sv
// Round-robin arbiter: 16 requesters, one shared resource.
// Registered grant index with release and optional hold timeout.
module rr_arb16
    import rr_arb16_pkg::*;
#(
    parameter int TIMEOUT = 8,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_REQ-1:0]  req,
    input  logic              rel,
    output logic              gnt_valid,
    output logic [IDX_W-1:0]  gnt_idx,
    output logic [N_REQ-1:0]  gnt,
    output logic              timeout
);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [0:0]       state;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic             to_q;

    logic             scan_hit;
    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] cand;
    logic             drop;
    logic             to_hit;
    logic [N_REQ-1:0] deco_o;

    // Descending scan so the candidate closest to ptr wins.
    always_comb begin
        scan_hit = 1'b0;
        scan_idx = ptr;
        cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    assign drop   = rel || !req[idx_q];
    assign to_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx_q <= '0;
            ptr   <= '0;
            cnt   <= '0;
            to_q  <= 1'b0;
        end else begin
            to_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en && scan_hit) begin
                        state <= ST_BUSY;
                        idx_q <= scan_idx;
                        ptr   <= scan_idx + IDX_W'(1);
                        cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (drop) begin
                        state <= ST_IDLE;
                    end else if (to_hit) begin
                        state <= ST_IDLE;
                        to_q  <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    deco416 u_deco (
        .x (idx_q),
        .o (deco_o)
    );

    assign gnt_valid = (state == ST_BUSY);
    assign gnt_idx   = idx_q;
    assign gnt       = deco_o & {N_REQ{gnt_valid}};
    assign timeout   = to_q;
endmodule

// File: tb/tb_rr_arb16.sv
// Bench for rr_arb16: directed scenarios plus random traffic
// checked against a cycle-level behavioural model.
module tb_rr_arb16;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] req = '0;
    logic        rel = 1'b0;
    logic        gnt_valid;
    logic [3:0]  gnt_idx;
    logic [15:0] gnt;
    logic        timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    // behavioural model state
    bit m_busy = 0;
    int m_idx  = 0;
    int m_ptr  = 0;
    int m_held = 0;
    bit m_to   = 0;
    localparam int T = 8;

    rr_arb16 #(.TIMEOUT(T), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .rel       (rel),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt       (gnt),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_ptr = 0;
        m_held = 0; m_to = 0;
    endtask

    task automatic model_edge(input bit e, input logic [15:0] r,
                              input bit rl);
        bit found;
        m_to = 0;
        if (m_busy) begin
            m_held++;
            if (rl || !r[m_idx]) begin
                m_busy = 0;
            end else if (T != 0 && m_held == T) begin
                m_busy = 0;
                m_to = 1;
            end
        end else if (e && r != 16'h0) begin
            found = 0;
            for (int k = 0; k < 16; k++) begin
                if (!found && r[(m_ptr + k) % 16]) begin
                    found = 1;
                    m_idx = (m_ptr + k) % 16;
                end
            end
            m_busy = 1;
            m_held = 0;
            m_ptr  = (m_idx + 1) % 16;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] eg;
        eg = m_busy ? (16'h0001 << m_idx) : 16'h0000;
        chk({tag, ".valid"}, {15'h0, gnt_valid}, {15'h0, m_busy});
        chk({tag, ".idx"}, {12'h0, gnt_idx}, 16'(m_idx));
        chk({tag, ".gnt"}, gnt, eg);
        chk({tag, ".timeout"}, {15'h0, timeout}, {15'h0, m_to});
    endtask

    task automatic cyc(input string tag, input bit e,
                       input logic [15:0] r, input bit rl);
        en = e; req = r; rel = rl;
        @(posedge clk);
        model_edge(e, r, rl);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #2 rst = 1'b0;
    endtask

    initial begin
        #1;
        model_reset();
        check_all("reset");
        #12 rst = 1'b0;

        // first grant after reset
        cyc("first", 1, 16'h0001, 0);
        chk("first.lit_idx", {12'h0, gnt_idx}, 16'h0000);
        chk("first.lit_gnt", gnt, 16'h0001);
        cyc("first_rel", 1, 16'h0001, 1);

        // alternate 0 / 15
        do_reset("rst_alt");
        for (int k = 0; k < 4; k++) begin
            cyc("alt", 1, 16'h8001, 0);
            chk("alt.lit", {12'h0, gnt_idx}, (k % 2) ? 16'd15 : 16'd0);
            cyc("alt_rel", 1, 16'h8001, 1);
            chk("alt.dead", {15'h0, gnt_valid}, 16'h0);
        end

        // full request: pointer walks 0..15 then wraps
        do_reset("rst_wrap");
        for (int k = 0; k < 17; k++) begin
            cyc("wrap", 1, 16'hFFFF, 0);
            chk("wrap.lit", {12'h0, gnt_idx}, 16'(k % 16));
            cyc("wrap_rel", 1, 16'hFFFF, 1);
        end

        // hold timeout on requester 4
        do_reset("rst_to");
        cyc("to_gnt", 1, 16'h0010, 0);
        for (int k = 0; k < 7; k++) cyc("to_hold", 1, 16'h0010, 0);
        chk("to.still", {15'h0, gnt_valid}, 16'h1);
        cyc("to_fire", 1, 16'h0010, 0);
        chk("to.lit", {15'h0, timeout}, 16'h1);
        cyc("to_regnt", 1, 16'h0010, 0);
        chk("to.regnt", {12'h0, gnt_idx}, 16'd4);
        for (int k = 0; k < 7; k++) cyc("to_hold2", 1, 16'h0010, 0);
        cyc("to_relco", 1, 16'h0010, 1);
        chk("to.relco", {15'h0, timeout}, 16'h0);

        // requester drops its line
        do_reset("rst_drop");
        cyc("drop_gnt", 1, 16'h0008, 0);
        cyc("drop", 1, 16'h0000, 0);
        chk("drop.lit", {15'h0, gnt_valid}, 16'h0);

        // en=0 does not revoke; rel in IDLE ignored
        cyc("en_gnt", 1, 16'h0004, 0);
        cyc("en_off", 0, 16'h0004, 0);
        cyc("en_rel", 0, 16'h0004, 1);
        cyc("idle_rel", 1, 16'h0000, 1);

        // async reset mid-grant
        do_reset("rst_mid0");
        cyc("mid_gnt", 1, 16'h0080, 0);
        do_reset("rst_mid");
        chk("mid.lit", gnt, 16'h0000);
        cyc("mid_a", 1, 16'h0081, 0);
        chk("mid.first", {12'h0, gnt_idx}, 16'd0);
        cyc("mid_rel", 1, 16'h0081, 1);
        cyc("mid_b", 1, 16'h0081, 0);
        chk("mid.second", {12'h0, gnt_idx}, 16'd7);

        // random traffic
        do_reset("rst_rand");
        for (int k = 0; k < 600; k++) begin
            logic [15:0] r;
            bit e, rl;
            case ($urandom_range(0, 3))
                0: r = 16'h0;
                1: r = 16'h1 << $urandom_range(0, 15);
                2: r = 16'($urandom);
                default: r = 16'($urandom) | 16'($urandom);
            endcase
            if ($urandom_range(0, 3) != 0 && m_busy)
                r[m_idx] = 1'b1;
            e  = ($urandom_range(0, 7) != 0);
            rl = ($urandom_range(0, 5) == 0);
            cyc("rand", e, r, rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
